// File: rtl/product_accumulator_if.sv
// product_accumulator_if: term input and batch result handshake bundle for the accumulator
interface product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  out_count;
  logic              overflow;
  modport master (
    output in_valid, prod, in_last, out_ready,
    input  in_ready, out_valid, acc_out, out_count, overflow
  );
  modport slave (
    input  in_valid, prod, in_last, out_ready,
    output in_ready, out_valid, acc_out, out_count, overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums a batch of multiplier products and presents total, term count and sticky overflow
module product_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, res_acc_q, res_acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, res_cnt_q, res_cnt_d, cnt_inc;
  logic             ovf_q, ovf_d, res_ovf_q, res_ovf_d;
  logic             accept, drain, close, ovf_next;
  logic [ACC_W:0]   sum;
  // handshake strobes are decoded from state only, so ready/valid never depend on the inputs
  assign accept   = (state_q == ACCUM) && bus.in_valid;
  assign drain    = (state_q == HOLD) && bus.out_ready;
  assign sum      = {1'b0, acc_q} + (ACC_W + 1)'(bus.prod);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign ovf_next = ovf_q | sum[ACC_W];
  assign close    = bus.in_last || (cnt_inc == CNT_W'(MAX_TERMS));
  // next-state: accumulate on accept, latch result on batch close, clear on result drain
  always_comb begin
    state_d   = drain ? ACCUM : (accept && close) ? HOLD : state_q;
    acc_d     = drain ? '0 : accept ? sum[ACC_W-1:0] : acc_q;
    cnt_d     = drain ? '0 : accept ? cnt_inc : cnt_q;
    ovf_d     = drain ? 1'b0 : accept ? ovf_next : ovf_q;
    res_acc_d = (accept && close) ? sum[ACC_W-1:0] : res_acc_q;
    res_cnt_d = (accept && close) ? cnt_inc : res_cnt_q;
    res_ovf_d = (accept && close) ? ovf_next : res_ovf_q;
  end
  // state and datapath registers; reset discards any partial batch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_acc_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_acc_q <= res_acc_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
    end
  end
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.acc_out   = res_acc_q;
  assign bus.out_count = res_cnt_q;
  assign bus.overflow  = res_ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vector checks of the product accumulator at default and narrowed widths
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;
  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(8), .ACC_W(12), .CNT_W(5)) ifa ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(10), .CNT_W(5)) ifb ();

  product_accumulator #(.PROD_W(8), .ACC_W(12), .MAX_TERMS(16), .CNT_W(5)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  product_accumulator #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16), .CNT_W(5)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    logic       v;
    logic [7:0] p;
    logic       l;
    logic       r;
    logic       e_rdy;
    logic       e_ov;
    logic       chk;
    int         e_acc;
    int         e_cnt;
    logic       e_of;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string n, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic exp_hs(input string t, input int rdy, input int ov);
    chk({t, ".in_ready"}, int'(ifa.in_ready), rdy);
    chk({t, ".out_valid"}, int'(ifa.out_valid), ov);
  endtask

  task automatic exp_res(input string t, input int acc, input int cnt, input int of);
    chk({t, ".acc_out"}, int'(ifa.acc_out), acc);
    chk({t, ".out_count"}, int'(ifa.out_count), cnt);
    chk({t, ".overflow"}, int'(ifa.overflow), of);
  endtask

  task automatic drv_a(input logic v, input logic [7:0] p, input logic l, input logic r);
    ifa.in_valid  = v;
    ifa.prod      = p;
    ifa.in_last   = l;
    ifa.out_ready = r;
  endtask

  initial begin
    drv_a(0, 0, 0, 0);
    ifb.in_valid = 0; ifb.prod = 0; ifb.in_last = 0; ifb.out_ready = 0;
    tbl[0]  = '{1, 225, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 225, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 225, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 225, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 255, 0, 1, 0, 1, 1, 900, 4, 0};
    tbl[5]  = '{1, 6, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 255, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 255, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 9, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 255, 0, 0, 0, 1, 1, 15, 3, 0};
    tbl[11] = '{0, 255, 0, 1, 0, 1, 1, 15, 3, 0};
    tbl[12] = '{0, 255, 0, 0, 1, 0, 0, 0, 0, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      exp_hs($sformatf("vec%0d", i), int'(tbl[i].e_rdy), int'(tbl[i].e_ov));
      if (tbl[i].chk) exp_res($sformatf("vec%0d", i), tbl[i].e_acc, tbl[i].e_cnt, int'(tbl[i].e_of));
      drv_a(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].r);
    end
    // MAX_TERMS auto-close with 20 ones and no in_last
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_hs($sformatf("max%0d", i), 1, 0);
      drv_a(1, 1, 0, 1);
    end
    @(negedge clk);
    exp_hs("max_hold", 0, 1);
    exp_res("max_hold", 16, 16, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_hs($sformatf("max_next%0d", i), 1, 0);
    end
    @(negedge clk);
    exp_hs("max_tail", 1, 0);
    drv_a(1, 1, 1, 1);
    @(negedge clk);
    exp_hs("max_tail_res", 0, 1);
    exp_res("max_tail_res", 5, 5, 0);
    drv_a(0, 255, 0, 1);
    // in_last coinciding with the MAX_TERMS boundary closes one batch only
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drv_a(1, 3, i == 15, 1);
    end
    @(negedge clk);
    exp_hs("coin_hold", 0, 1);
    exp_res("coin_hold", 48, 16, 0);
    drv_a(0, 255, 0, 1);
    @(negedge clk);
    exp_hs("coin_idle0", 1, 0);
    @(negedge clk);
    exp_hs("coin_idle1", 1, 0);
    drv_a(1, 2, 1, 0);
    @(negedge clk);
    exp_hs("coin_next", 0, 1);
    exp_res("coin_next", 2, 1, 0);
    drv_a(0, 255, 0, 1);
    @(negedge clk);
    drv_a(1, 50, 1, 0);
    // result held under back-pressure while upstream keeps presenting a term
    @(negedge clk);
    exp_res("bp_first", 50, 1, 0);
    drv_a(1, 77, 1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_hs($sformatf("bp%0d", i), 0, 1);
      exp_res($sformatf("bp%0d", i), 50, 1, 0);
    end
    ifa.out_ready = 1'b1;
    @(negedge clk);
    exp_hs("bp_release", 1, 0);
    ifa.out_ready = 1'b0;
    @(negedge clk);
    exp_hs("bp_accept", 0, 1);
    exp_res("bp_accept", 77, 1, 0);
    drv_a(0, 255, 0, 1);
    @(negedge clk);
    drv_a(1, 100, 0, 0);
    // asynchronous reset mid-batch
    repeat (2) @(negedge clk);
    drv_a(0, 255, 0, 0);
    #2 rst = 1'b1;
    #1;
    exp_hs("arst", 1, 0);
    exp_res("arst", 0, 0, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    drv_a(1, 7, 1, 0);
    @(negedge clk);
    exp_hs("arst_next", 0, 1);
    exp_res("arst_next", 7, 1, 0);
    drv_a(0, 255, 0, 1);
    // narrowed accumulator: wraps modulo 1024 and flags overflow
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ifb.in_valid = 1; ifb.prod = 225; ifb.in_last = (i == 4); ifb.out_ready = 0;
    end
    @(negedge clk);
    chk("w10.out_valid", int'(ifb.out_valid), 1);
    chk("w10.acc_out", int'(ifb.acc_out), 101);
    chk("w10.out_count", int'(ifb.out_count), 5);
    chk("w10.overflow", int'(ifb.overflow), 1);
    ifb.in_valid = 0; ifb.out_ready = 1;
    @(negedge clk);
    chk("w10.in_ready", int'(ifb.in_ready), 1);
    ifb.in_valid = 1; ifb.prod = 3; ifb.in_last = 1; ifb.out_ready = 0;
    @(negedge clk);
    chk("w10b.out_valid", int'(ifb.out_valid), 1);
    chk("w10b.acc_out", int'(ifb.acc_out), 3);
    chk("w10b.out_count", int'(ifb.out_count), 1);
    chk("w10b.overflow", int'(ifb.overflow), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
